// File: rtl/ops_pkg.sv
// Shared operation and executor-state encodings for the FIFO and the op executor.
package ops_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_MUL = 2'd3
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } exec_state_t;

endpackage

// File: rtl/op_executor_if.sv
// FIFO read side plus result handshake of the op executor.
// OP_EXEC_OVF_EN adds the ovf flag that travels with result.
interface op_executor_if #(
  parameter int DATA_WIDTH = 8
);
  import ops_pkg::*;

  // Pop when fifo_pop && !fifo_empty at a rising edge; a result transfers on the
  // edge where result_valid && result_ready, and result stays stable until then.
  operation_t            op_in;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] operand;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic                  result_ready;
`ifdef OP_EXEC_OVF_EN
  logic                  ovf;
`endif

  modport master (
    input  op_in, fifo_empty, operand, result_ready,
`ifdef OP_EXEC_OVF_EN
    output ovf,
`endif
    output fifo_pop, result, result_valid
  );

  modport slave (
    output op_in, fifo_empty, operand, result_ready,
`ifdef OP_EXEC_OVF_EN
    input  ovf,
`endif
    input  fifo_pop, result, result_valid
  );

endinterface

// File: rtl/op_executor_shift_add_mul.sv
// Iterative LSB-first shift-add multiplier; product is valid combinationally while done is high.
module shift_add_mul #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    done
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [2*DATA_WIDTH-1:0] partial_q, partial_d;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [CW-1:0]           count_q;
  logic                    run_q;

  // The last bit is folded in combinationally so the product lands on the W-th cycle.
  always_comb begin
    partial_d = partial_q;
    if (mplier_q[0]) partial_d = partial_q + mcand_q;
  end

  assign product = partial_d;
  assign done    = run_q && (count_q == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      partial_q <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      run_q     <= 1'b0;
    end else if (abort) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      mcand_q   <= {{DATA_WIDTH{1'b0}}, a};
      mplier_q  <= b;
      partial_q <= '0;
      count_q   <= '0;
      run_q     <= 1'b1;
    end else if (run_q) begin
      partial_q <= partial_d;
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_q >> 1;
      count_q   <= count_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/op_executor.sv
// Op executor: pops operations from the FIFO, applies them to an accumulator, hands results out.
// OP_EXEC_OVF_EN adds an ovf flag registered with each result.
module op_executor
  import ops_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ACC_INIT   = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  op_executor_if.master bus,
  output logic        busy,
  output exec_state_t state_o
);
  exec_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    ovf_d;
  logic                    pop;
  logic                    mul_start;
  logic                    mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH:0]     diff;

  // Top bit of each holds carry-out / borrow respectively.
  assign sum  = {1'b0, acc_q} + {1'b0, bus.operand};
  assign diff = {1'b0, acc_q} - {1'b0, bus.operand};

  shift_add_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush),
    .a       (acc_q),
    .b       (bus.operand),
    .product (mul_product),
    .done    (mul_done)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    ovf_d     = 1'b0;
    pop       = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.fifo_empty && !flush) begin
          pop = 1'b1;
          unique case (bus.op_in)
            OP_ADD: begin
              acc_d    = sum[DATA_WIDTH-1:0];
              result_d = sum[DATA_WIDTH-1:0];
              ovf_d    = sum[DATA_WIDTH];
              state_d  = ST_OUT;
            end
            OP_SUB: begin
              acc_d    = diff[DATA_WIDTH-1:0];
              result_d = diff[DATA_WIDTH-1:0];
              ovf_d    = diff[DATA_WIDTH];
              state_d  = ST_OUT;
            end
            OP_MUL: begin
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          acc_d    = mul_product[DATA_WIDTH-1:0];
          result_d = mul_product[DATA_WIDTH-1:0];
          ovf_d    = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, including a same-cycle handshake.
    if (flush) begin
      state_d  = ST_IDLE;
      acc_d    = ACC_INIT;
      result_d = ACC_INIT;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= ACC_INIT;
      result_q <= ACC_INIT;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

`ifdef OP_EXEC_OVF_EN
  logic ovf_q;
  // ovf only updates when a new result is written, so it stays paired with result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       ovf_q <= 1'b0;
    else if (flush)                                ovf_q <= 1'b0;
    else if (state_d == ST_OUT && state_q != ST_OUT) ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

  assign bus.fifo_pop     = pop;
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == ST_OUT);
  assign busy             = (state_q != ST_IDLE);
  assign state_o          = state_q;

endmodule

// File: tb/tb_op_executor.sv
// Self-checking bench for op_executor against an arithmetic accumulator model.
// Build with +define+OP_EXEC_OVF_EN to also check the ovf flag.
module tb_op_executor;
  import ops_pkg::*;

  localparam int W = 8;
  localparam int MOD = 1 << W;
  localparam logic [W-1:0] ACC_INIT = '0;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        busy;
  exec_state_t state_dbg;

  int vectors;
  int miscompares;
  int acc_m;

  op_executor_if #(.DATA_WIDTH(W)) bus ();

  op_executor #(.DATA_WIDTH(W), .ACC_INIT(ACC_INIT)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus.master),
    .busy    (busy),
    .state_o (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    flush            = 1'b0;
    bus.fifo_empty   = 1'b1;
    bus.op_in        = OP_NOP;
    bus.operand      = '0;
    bus.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pop", bus.fifo_pop, 0);
    check("rst_result", bus.result, ACC_INIT);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
`ifdef OP_EXEC_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    rst   = 1'b0;
    acc_m = int'(ACC_INIT);
  endtask

  // Issues one op from IDLE and follows it to the cycle where the handshake happens.
  task automatic run_op(input operation_t op, input logic [W-1:0] opnd, input int stall);
    int full;
    int exp_res;
    int exp_ovf;
    int lat;
    @(negedge clk);
    bus.op_in        = op;
    bus.operand      = opnd;
    bus.fifo_empty   = 1'b0;
    bus.result_ready = (stall == 0);
    #1;
    check("pop_in_idle", bus.fifo_pop, 1);
    check("idle_not_busy", busy, 0);
    check("idle_no_valid", bus.result_valid, 0);
    if (op == OP_NOP) return;
    exp_ovf = 0;
    case (op)
      OP_ADD: begin full = acc_m + int'(opnd); exp_ovf = int'(full >= MOD); end
      OP_SUB: begin full = acc_m - int'(opnd); exp_ovf = int'(int'(opnd) > acc_m); end
      default: begin full = acc_m * int'(opnd); exp_ovf = int'(full >= MOD); end
    endcase
    exp_res = ((full % MOD) + MOD) % MOD;
    acc_m   = exp_res;
    lat     = (op == OP_MUL) ? W : 0;
    @(negedge clk);
    bus.op_in      = operation_t'($urandom_range(0, 3));
    bus.operand    = W'($urandom_range(0, MOD - 1));
    bus.fifo_empty = 1'b0;
    #1;
    for (int i = 0; i < lat; i++) begin
      check("mul_no_valid", bus.result_valid, 0);
      check("mul_busy", busy, 1);
      check("mul_no_pop", bus.fifo_pop, 0);
      @(negedge clk);
      #1;
    end
    check("out_valid", bus.result_valid, 1);
    check("out_result", bus.result, exp_res);
    check("out_no_pop", bus.fifo_pop, 0);
`ifdef OP_EXEC_OVF_EN
    check("out_ovf", bus.ovf, exp_ovf);
`endif
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", bus.result_valid, 1);
      check("stall_result", bus.result, exp_res);
      check("stall_busy", busy, 1);
      check("stall_no_pop", bus.fifo_pop, 0);
      @(negedge clk);
      if (s == stall - 1) bus.result_ready = 1'b1;
      #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    do_reset();

    // basic adds, back-to-back with ready high
    run_op(OP_ADD, 8'd5, 0);
    run_op(OP_ADD, 8'd3, 0);
    // wrap on add and borrow on sub
    run_op(OP_ADD, 8'd192, 0);
    run_op(OP_ADD, 8'd100, 0);
    run_op(OP_SUB, 8'd50, 0);
    // reach acc=12, then multiplies
    run_op(OP_ADD, 8'd18, 0);
    run_op(OP_MUL, 8'd11, 0);
    run_op(OP_MUL, 8'd2, 0);
    // downstream stall
    run_op(OP_ADD, 8'd1, 5);

    // nops pop every cycle without producing results
    do_reset();
    run_op(OP_NOP, 8'd9, 0);
    run_op(OP_NOP, 8'd4, 0);
    run_op(OP_NOP, 8'd1, 0);
    run_op(OP_ADD, 8'd7, 0);

    // flush three cycles into a multiply
    @(negedge clk);
    bus.op_in = OP_MUL; bus.operand = 8'd3; bus.fifo_empty = 1'b0; bus.result_ready = 1'b1;
    #1 check("flush_mul_pop", bus.fifo_pop, 1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_mul_no_pop", bus.fifo_pop, 0);
    @(negedge clk);
    flush = 1'b0; bus.fifo_empty = 1'b1;
    #1;
    check("flush_state", 32'(state_dbg), 32'(ST_IDLE));
    check("flush_no_valid", bus.result_valid, 0);
    check("flush_result", bus.result, ACC_INIT);
    acc_m = int'(ACC_INIT);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      #1 check("flush_no_stray", bus.result_valid, 0);
    end
    // flush in IDLE blocks the pop
    @(negedge clk);
    bus.op_in = OP_ADD; bus.fifo_empty = 1'b0; flush = 1'b1;
    #1 check("flush_idle_no_pop", bus.fifo_pop, 0);
    @(negedge clk);
    flush = 1'b0; bus.fifo_empty = 1'b1;
    #1 check("flush_idle_busy", busy, 0);
    run_op(OP_ADD, 8'd7, 0);

    // async reset while holding a result
    @(negedge clk);
    bus.op_in = OP_ADD; bus.operand = 8'd9; bus.fifo_empty = 1'b0; bus.result_ready = 1'b0;
    @(negedge clk);
    bus.fifo_empty = 1'b1;
    #1 check("pre_rst_valid", bus.result_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", bus.result_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_result", bus.result, ACC_INIT);
    @(negedge clk);
    rst   = 1'b0;
    acc_m = int'(ACC_INIT);

    // random operations with random stalls
    for (int n = 0; n < 40; n++) begin
      run_op(operation_t'($urandom_range(0, 3)), W'($urandom_range(0, MOD - 1)),
             int'($urandom_range(0, 2)));
    end
    @(negedge clk);
    bus.fifo_empty = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/op_executor.md
Name: op_executor

Overview:
- Consumer end of the operation FIFO.
- Pops one operation_t (nop/add/sub/mul) at a time from the FIFO read side and applies it to an internal accumulator using an operand supplied alongside.
- Presents each result on a valid/ready output.
- Sits directly downstream of fifo: its empty/rdata drive this block, and this block drives fifo_pop.

Parameters:
- DATA_WIDTH, 8, width of operand, accumulator and result.
- ACC_INIT, 0, accumulator value after reset or flush.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous clear; same cycle as the FIFO flush.
- op_in  input  2 (operation_t)  FIFO rdata, valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- operand  input  DATA_WIDTH  operand paired with op_in; sampled on the pop cycle.
- fifo_pop  output  1  pop strobe to FIFO (combinational).
- result  output  DATA_WIDTH  accumulator value after the completed op.
- result_valid  output  1  result available.
- result_ready  input  1  downstream accepts result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=ACC_INIT, result=ACC_INIT.
  - result_valid=0, busy=0, fifo_pop=0, mul counter=0.
  - Reset mid-multiply or mid-OUT aborts without side effects.
- States: IDLE, MUL, OUT.
- IDLE:
  - fifo_pop = !fifo_empty && !flush.
  - On the pop edge, op_in and operand are latched.
  - nop: acc unchanged, no result produced, stay IDLE. Back-to-back nops pop every cycle.
  - add: acc <= acc + operand, mod 2^DATA_WIDTH; result <= same; next state OUT.
  - sub: acc <= acc - operand, mod 2^DATA_WIDTH; next state OUT.
  - mul: load multiplier=operand, multiplicand=acc, partial=0, count=0; next state MUL.
- MUL:
  - Iterative shift-add, one multiplier bit per cycle, LSB first.
  - Exactly DATA_WIDTH cycles in MUL.
  - Then acc and result take the low DATA_WIDTH bits of the product; next state OUT.
  - fifo_pop=0 throughout.
- OUT:
  - result_valid=1; result held stable until the handshake.
  - On result_valid && result_ready: next state IDLE.
  - fifo_pop=0 in OUT; a new pop happens only from IDLE, so there is one bubble per non-nop op.
- Latency, measured from the pop edge at cycle N:
  - add/sub: result_valid high in cycle N+1.
  - mul: result_valid high in cycle N+1+DATA_WIDTH.
- Throughput: add/sub with result_ready tied high completes one op per 2 cycles.
- Flush, any state:
  - Next edge: state=IDLE, acc=ACC_INIT, result_valid=0, pending result discarded, mul aborted.
  - fifo_pop forced 0 that cycle.
- fifo_empty=1 in IDLE: no pop, hold.
- op_in is ignored outside the pop cycle.
- Simultaneous flush and result_ready in OUT: flush wins; the handshake does not count as delivered.
- Wrap: add/sub/mul wrap silently unless the optional feature is enabled.

Optional Feature:
- Macro: OP_EXEC_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside result and valid with result_valid.
  - add: set on unsigned carry-out.
  - sub: set on borrow (operand > acc).
  - mul: set if any product bit at or above DATA_WIDTH is nonzero.
  - Cleared on reset or flush.
- Undefined: no ovf port; wrapping only.

Decomposition:
- Shared package ops_pkg:
  - operation_t (nop=0, add=1, sub=2, mul=3), moved from fifo so both blocks import it.
  - exec_state_t (IDLE, MUL, OUT).
- One sub-module: shift_add_mul.
  - Ports: clk, rst, start, abort, a, b, product, done.
  - Iterative multiplier, DATA_WIDTH cycles.
- Top module holds the FSM, accumulator and handshake.

Test Plan:
- Reset then sequence add 5, add 3 with result_ready=1 -> results 5 then 8; each result_valid exactly one cycle after its pop; fifo_pop high only in IDLE cycles with fifo_empty=0.
- acc=200, add 100 (DATA_WIDTH=8) -> result 44.
  - With OP_EXEC_OVF_EN: ovf=1.
  - Then sub 50 -> result 250; with OP_EXEC_OVF_EN: ovf=1 (borrow).
- acc=12, mul 11 -> result_valid exactly 9 cycles after the pop edge, result 132.
  - Then mul 2 -> 8 (264 mod 256); with OP_EXEC_OVF_EN: ovf=1.
- result_ready=0 for 5 cycles in OUT -> result and result_valid stable, no fifo_pop, busy=1; releasing result_ready returns to IDLE next edge.
- Three nops, then add 7, from reset -> three consecutive pops with no result_valid; then result 7.
- Flush asserted 3 cycles into a mul -> next cycle IDLE, acc=ACC_INIT, no result_valid.
  - Async rst pulse in OUT -> result_valid drops immediately.
